uar_frame_ctrl: RTL and testbench

// Frame controller behind the 162-bit UART packet receiver. It detects frame

---
 rtl/uar_frame_ctrl_if.sv | 13 +
 rtl/uar_frame_ctrl.sv | 147 ++++++++++++++
 tb/tb_uar_frame_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uar_frame_ctrl_if.sv
// Cell-write bus between the frame controller and board memory.
interface uar_frame_ctrl_if #(
  parameter int ADDR_W = 7,
  parameter int CELL_W = 2
);
  logic              wr_ready_in;
  logic              cell_we_out;
  logic [ADDR_W-1:0] cell_addr_out;
  logic [CELL_W-1:0] cell_val_out;

  modport master (input wr_ready_in, output cell_we_out, cell_addr_out, cell_val_out);
  modport slave  (output wr_ready_in, input cell_we_out, cell_addr_out, cell_val_out);
endinterface

// File: rtl/uar_frame_ctrl.sv
// Frame controller: latches a 162-bit UART packet, validates its 81 board cells
// and streams them into board memory, resetting the receiver on errors.
module uar_frame_ctrl #(
  parameter int N_CELLS   = 81,
  parameter int CELL_W    = 2,
  parameter int PKT_LNGTH = 162,
  parameter int ADDR_W    = 7,
  parameter int STALL_MAX = 1024,
  parameter int RST_CYC   = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rx_ready_in,
  input  logic [PKT_LNGTH-1:0] rx_data_in,
  uar_frame_ctrl_if.master     cell_bus,
  output logic                 frame_done_out,
  output logic                 frame_err_out,
  output logic [1:0]           err_code_out,
  output logic [15:0]          frame_count_out,
  output logic                 rx_rst_out,
  output logic                 busy_out
);

  localparam int STALL_W = $clog2(STALL_MAX);
  localparam int RST_W   = $clog2(RST_CYC) + 1;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_STALL   = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;

  typedef enum logic [2:0] {IDLE, CHECK, WRITE, DONE, ERR} state_t;

  state_t               state_q, state_d;
  logic                 rdy_q;
  logic [PKT_LNGTH-1:0] buf_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [STALL_W-1:0]   stall_q;
  logic [RST_W-1:0]     rst_cnt_q;
  logic [1:0]           err_code_q;
  logic [15:0]          frame_cnt_q;

  logic rx_edge;
  logic xfer;
  logic stall_limit;
  logic last_cell;

  function automatic logic has_illegal(input logic [PKT_LNGTH-1:0] frame);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_CELLS; i++)
      if (frame[i*CELL_W +: CELL_W] == {CELL_W{1'b1}}) hit = 1'b1;
    return hit;
  endfunction

  assign rx_edge     = !rdy_q && rx_ready_in;
  assign xfer        = (state_q == WRITE) && cell_bus.wr_ready_in;
  assign stall_limit = (stall_q == STALL_W'(STALL_MAX - 1));
  assign last_cell   = (addr_q == ADDR_W'(N_CELLS - 1));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (rx_edge) state_d = CHECK;
      CHECK: state_d = has_illegal(buf_q) ? ERR : WRITE;
      WRITE: begin
        if (xfer && last_cell)                          state_d = DONE;
        else if (!cell_bus.wr_ready_in && stall_limit)  state_d = ERR;
      end
      DONE:  state_d = IDLE;
      ERR:   if (rst_cnt_q == RST_W'(RST_CYC - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Cells leave from the bottom of the buffer, so the value bus is a plain register slice.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rdy_q       <= 1'b1;
      buf_q       <= '0;
      addr_q      <= '0;
      stall_q     <= '0;
      rst_cnt_q   <= '0;
      err_code_q  <= ERR_NONE;
      frame_cnt_q <= '0;
    end else begin
      rdy_q <= (state_q == ERR) ? 1'b1 : rx_ready_in;
      if (rx_edge && (state_q inside {CHECK, WRITE, DONE})) err_code_q <= ERR_OVERRUN;
      unique case (state_q)
        IDLE: if (rx_edge) begin
          buf_q      <= rx_data_in;
          err_code_q <= ERR_NONE;
        end
        CHECK: begin
          addr_q    <= '0;
          stall_q   <= '0;
          rst_cnt_q <= '0;
          if (has_illegal(buf_q)) err_code_q <= ERR_ILLEGAL;
        end
        WRITE: begin
          if (xfer) begin
            addr_q  <= addr_q + ADDR_W'(1);
            buf_q   <= buf_q >> CELL_W;
            stall_q <= '0;
          end else if (stall_limit) begin
            err_code_q <= ERR_STALL;
          end else begin
            stall_q <= stall_q + STALL_W'(1);
          end
        end
        DONE: frame_cnt_q <= frame_cnt_q + 16'd1;
        ERR:  rst_cnt_q   <= rst_cnt_q + RST_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    cell_bus.cell_we_out   = 1'b0;
    cell_bus.cell_addr_out = addr_q;
    cell_bus.cell_val_out  = '0;
    frame_done_out         = 1'b0;
    frame_err_out          = 1'b0;
    rx_rst_out             = 1'b0;
    busy_out               = (state_q != IDLE);
    err_code_out           = err_code_q;
    frame_count_out        = frame_cnt_q;
    unique case (state_q)
      WRITE: begin
        cell_bus.cell_we_out  = 1'b1;
        cell_bus.cell_val_out = buf_q[CELL_W-1:0];
      end
      DONE: frame_done_out = 1'b1;
      ERR: begin
        rx_rst_out    = 1'b1;
        frame_err_out = (rst_cnt_q == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uar_frame_ctrl.sv
// Directed bench for uar_frame_ctrl: good frames, illegal cells, stalls,
// overrun and mid-frame reset, with hand-derived cycle timing.
module tb_uar_frame_ctrl;
  localparam int N_CELLS = 81;

  logic         clk_in = 1'b0;
  logic         rst_n_in = 1'b0;
  logic         rx_ready_in = 1'b1;
  logic [161:0] rx_data_in = '0;
  logic         frame_done_out, frame_err_out, rx_rst_out, busy_out;
  logic [1:0]   err_code_out;
  logic [15:0]  frame_count_out;

  uar_frame_ctrl_if bus ();

  uar_frame_ctrl dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .rx_ready_in     (rx_ready_in),
    .rx_data_in      (rx_data_in),
    .cell_bus        (bus),
    .frame_done_out  (frame_done_out),
    .frame_err_out   (frame_err_out),
    .err_code_out    (err_code_out),
    .frame_count_out (frame_count_out),
    .rx_rst_out      (rx_rst_out),
    .busy_out        (busy_out)
  );

  always #5 clk_in = ~clk_in;

  int vec_cnt = 0;
  int miss_cnt = 0;

  logic [1:0] cap_val [0:N_CELLS-1];
  int n_wr, bad_order, done_k, done_n, err_k, err_n, rsthi_n, we_n;

  // pattern 0: alternating 01/10; 1: all 01 but cell 40 = 11; 2: 00/01/10 cycle
  function automatic logic [1:0] pat_cell(input int pat, input int i);
    logic [1:0] c;
    case (pat)
      0:       c = (i % 2 == 0) ? 2'b01 : 2'b10;
      1:       c = (i == 40) ? 2'b11 : 2'b01;
      2:       c = (i % 3 == 0) ? 2'b00 : ((i % 3 == 1) ? 2'b01 : 2'b10);
      default: c = 2'b10;
    endcase
    return c;
  endfunction

  function automatic logic [161:0] make_frame(input int pat);
    logic [161:0] f;
    f = '0;
    for (int i = 0; i < N_CELLS; i++) f[2*i +: 2] = pat_cell(pat, i);
    return f;
  endfunction

  // k counts periods after the registering edge of the ready rise: k=0 is CHECK.
  // mode 0: ready always; 1: ready on odd k; 2: ready for 10 writes only; 3: always + second edge
  task automatic run_frame(input logic [161:0] d, input int mode, input int ncyc);
    n_wr = 0; bad_order = 0; done_k = -1; done_n = 0;
    err_k = -1; err_n = 0; rsthi_n = 0; we_n = 0;
    @(posedge clk_in); #1 rx_ready_in = 1'b0; rx_data_in = d;
    @(posedge clk_in); #1 rx_ready_in = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk_in); #1;
      case (mode)
        1:       bus.wr_ready_in = (k % 2 == 1);
        2:       bus.wr_ready_in = (n_wr < 10);
        default: bus.wr_ready_in = 1'b1;
      endcase
      if (mode == 3 && k == 40) begin
        rx_ready_in = 1'b0;
        rx_data_in  = make_frame(3);
      end
      if (mode == 3 && k == 41) rx_ready_in = 1'b1;
      @(negedge clk_in);
      if (bus.cell_we_out) begin
        we_n++;
        if (bus.wr_ready_in) begin
          if (int'(bus.cell_addr_out) != n_wr || n_wr >= N_CELLS) bad_order++;
          else cap_val[n_wr] = bus.cell_val_out;
          n_wr++;
        end
      end
      if (frame_done_out) begin done_n++; done_k = k; end
      if (frame_err_out)  begin err_n++;  err_k = k;  end
      if (rx_rst_out) rsthi_n++;
    end
    bus.wr_ready_in = 1'b1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    vec_cnt++;
    if ({bus.cell_we_out, bus.cell_addr_out, bus.cell_val_out} !== 10'd0) begin
      miss_cnt++;
      $display("FAIL reset_bus: we/addr/val=%b required 0", {bus.cell_we_out, bus.cell_addr_out, bus.cell_val_out});
    end
    vec_cnt++;
    if ({frame_done_out, frame_err_out, err_code_out, rx_rst_out, busy_out} !== 6'd0) begin
      miss_cnt++;
      $display("FAIL reset_ctrl: done/err/code/rxrst/busy=%b required 0",
               {frame_done_out, frame_err_out, err_code_out, rx_rst_out, busy_out});
    end
    vec_cnt++;
    if (frame_count_out !== 16'd0) begin
      miss_cnt++;
      $display("FAIL reset_count: got %0d required 0", frame_count_out);
    end
    @(posedge clk_in); #1 rst_n_in = 1'b1;
  endtask

  task automatic test_alternating;
    run_frame(make_frame(0), 0, 90);
    vec_cnt++;
    if (n_wr !== 81 || bad_order !== 0) begin
      miss_cnt++;
      $display("FAIL alt_writes: writes=%0d out_of_order=%0d required 81/0", n_wr, bad_order);
    end
    for (int i = 0; i < N_CELLS; i++) begin
      vec_cnt++;
      if (cap_val[i] !== pat_cell(0, i)) begin
        miss_cnt++;
        $display("FAIL alt_cell%0d: got %b required %b", i, cap_val[i], pat_cell(0, i));
      end
    end
    vec_cnt++;
    if (done_k !== 82 || done_n !== 1 || err_n !== 0) begin
      miss_cnt++;
      $display("FAIL alt_done: done at k=%0d pulses=%0d errs=%0d required 82/1/0", done_k, done_n, err_n);
    end
    vec_cnt++;
    if (frame_count_out !== 16'd1 || err_code_out !== 2'b00 || busy_out !== 1'b0) begin
      miss_cnt++;
      $display("FAIL alt_status: count=%0d code=%b busy=%b required 1/00/0", frame_count_out, err_code_out, busy_out);
    end
  endtask

  task automatic test_illegal;
    run_frame(make_frame(1), 0, 20);
    vec_cnt++;
    if (we_n !== 0) begin
      miss_cnt++;
      $display("FAIL ill_we: write cycles=%0d required 0", we_n);
    end
    vec_cnt++;
    if (err_n !== 1 || err_k !== 1 || done_n !== 0) begin
      miss_cnt++;
      $display("FAIL ill_pulse: errs=%0d at k=%0d dones=%0d required 1/1/0", err_n, err_k, done_n);
    end
    vec_cnt++;
    if (err_code_out !== 2'b01) begin
      miss_cnt++;
      $display("FAIL ill_code: got %b required 01", err_code_out);
    end
    vec_cnt++;
    if (rsthi_n !== 4 || frame_count_out !== 16'd1 || busy_out !== 1'b0) begin
      miss_cnt++;
      $display("FAIL ill_rxrst: rx_rst cycles=%0d count=%0d busy=%b required 4/1/0", rsthi_n, frame_count_out, busy_out);
    end
  endtask

  task automatic test_half_ready;
    run_frame(make_frame(2), 1, 170);
    vec_cnt++;
    if (n_wr !== 81 || bad_order !== 0) begin
      miss_cnt++;
      $display("FAIL half_writes: writes=%0d out_of_order=%0d required 81/0", n_wr, bad_order);
    end
    for (int i = 0; i < N_CELLS; i++) begin
      vec_cnt++;
      if (cap_val[i] !== pat_cell(2, i)) begin
        miss_cnt++;
        $display("FAIL half_cell%0d: got %b required %b", i, cap_val[i], pat_cell(2, i));
      end
    end
    vec_cnt++;
    if (done_k !== 162 || done_n !== 1) begin
      miss_cnt++;
      $display("FAIL half_done: done at k=%0d pulses=%0d required 162/1", done_k, done_n);
    end
    vec_cnt++;
    if (frame_count_out !== 16'd2 || err_code_out !== 2'b00) begin
      miss_cnt++;
      $display("FAIL half_status: count=%0d code=%b required 2/00", frame_count_out, err_code_out);
    end
  endtask

  task automatic test_stall;
    run_frame(make_frame(0), 2, 1045);
    vec_cnt++;
    if (n_wr !== 10 || bad_order !== 0) begin
      miss_cnt++;
      $display("FAIL stall_writes: writes=%0d out_of_order=%0d required 10/0", n_wr, bad_order);
    end
    vec_cnt++;
    if (err_n !== 1 || err_k !== 1035 || done_n !== 0) begin
      miss_cnt++;
      $display("FAIL stall_pulse: errs=%0d at k=%0d dones=%0d required 1/1035/0", err_n, err_k, done_n);
    end
    vec_cnt++;
    if (err_code_out !== 2'b10 || frame_count_out !== 16'd2) begin
      miss_cnt++;
      $display("FAIL stall_status: code=%b count=%0d required 10/2", err_code_out, frame_count_out);
    end
    vec_cnt++;
    if (rsthi_n !== 4 || busy_out !== 1'b0) begin
      miss_cnt++;
      $display("FAIL stall_rxrst: rx_rst cycles=%0d busy=%b required 4/0", rsthi_n, busy_out);
    end
  endtask

  task automatic test_overrun;
    run_frame(make_frame(2), 3, 95);
    vec_cnt++;
    if (n_wr !== 81 || bad_order !== 0) begin
      miss_cnt++;
      $display("FAIL ovr_writes: writes=%0d out_of_order=%0d required 81/0", n_wr, bad_order);
    end
    for (int i = 0; i < N_CELLS; i++) begin
      vec_cnt++;
      if (cap_val[i] !== pat_cell(2, i)) begin
        miss_cnt++;
        $display("FAIL ovr_cell%0d: got %b required %b", i, cap_val[i], pat_cell(2, i));
      end
    end
    vec_cnt++;
    if (done_k !== 82 || done_n !== 1 || err_n !== 0) begin
      miss_cnt++;
      $display("FAIL ovr_done: done at k=%0d pulses=%0d errs=%0d required 82/1/0", done_k, done_n, err_n);
    end
    vec_cnt++;
    if (err_code_out !== 2'b11 || frame_count_out !== 16'd3 || busy_out !== 1'b0) begin
      miss_cnt++;
      $display("FAIL ovr_status: code=%b count=%0d busy=%b required 11/3/0", err_code_out, frame_count_out, busy_out);
    end
  endtask

  task automatic test_reset_mid;
    bit found;
    found = 1'b0;
    bus.wr_ready_in = 1'b1;
    @(posedge clk_in); #1 rx_ready_in = 1'b0; rx_data_in = make_frame(0);
    @(posedge clk_in); #1 rx_ready_in = 1'b1;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk_in);
      if (bus.cell_we_out && bus.cell_addr_out == 7'd30) found = 1'b1;
    end
    vec_cnt++;
    if (!found) begin
      miss_cnt++;
      $display("FAIL mid_reach: addr 30 not seen within 100 cycles, required seen");
    end
    rst_n_in = 1'b0;
    #1;
    vec_cnt++;
    if ({bus.cell_we_out, bus.cell_addr_out, bus.cell_val_out} !== 10'd0) begin
      miss_cnt++;
      $display("FAIL mid_bus: we/addr/val=%b required 0", {bus.cell_we_out, bus.cell_addr_out, bus.cell_val_out});
    end
    vec_cnt++;
    if ({frame_done_out, frame_err_out, err_code_out, rx_rst_out, busy_out} !== 6'd0 || frame_count_out !== 16'd0) begin
      miss_cnt++;
      $display("FAIL mid_ctrl: done/err/code/rxrst/busy=%b count=%0d required 0/0",
               {frame_done_out, frame_err_out, err_code_out, rx_rst_out, busy_out}, frame_count_out);
    end
    @(posedge clk_in); #1 rst_n_in = 1'b1;
    run_frame(make_frame(2), 0, 90);
    vec_cnt++;
    if (n_wr !== 81 || bad_order !== 0) begin
      miss_cnt++;
      $display("FAIL mid_rewrite: writes=%0d out_of_order=%0d required 81/0", n_wr, bad_order);
    end
    vec_cnt++;
    if (cap_val[0] !== 2'b00 || cap_val[31] !== 2'b01 || cap_val[80] !== 2'b10) begin
      miss_cnt++;
      $display("FAIL mid_values: cells 0/31/80=%b/%b/%b required 00/01/10", cap_val[0], cap_val[31], cap_val[80]);
    end
    vec_cnt++;
    if (done_k !== 82 || frame_count_out !== 16'd1) begin
      miss_cnt++;
      $display("FAIL mid_done: done at k=%0d count=%0d required 82/1", done_k, frame_count_out);
    end
  endtask

  initial begin
    bus.wr_ready_in = 1'b1;
    test_reset();
    test_alternating();
    test_illegal();
    test_half_ready();
    test_stall();
    test_overrun();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
